// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// cdb_arbiter_if : request/result bundle of the CDB arbiter (master = arbiter side,
//                  slave = requesters and CDB consumer). Rev 1.0
interface cdb_arbiter_if #(
   parameter int  NUM_REQ = 4,
   parameter type T       = logic [31:0]
);
   localparam int SRC_W = $clog2(NUM_REQ);

   logic                     flush;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   T     [NUM_REQ-1:0]       req_data;
   logic                     cdb_valid;
   logic                     cdb_ready;
   T                         cdb_data;
   logic [SRC_W-1:0]         cdb_src;
   logic [NUM_REQ-1:0][31:0] perf_stall_cnt;

   modport master (
      input  flush, req_valid, req_data, cdb_ready,
      output req_ready, cdb_valid, cdb_data, cdb_src, perf_stall_cnt
   );

   modport slave (
      output flush, req_valid, req_data, cdb_ready,
      input  req_ready, cdb_valid, cdb_data, cdb_src, perf_stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// cdb_arbiter : round-robin CDB arbiter with one registered output stage and flush.
//               Optional stall counters under `CDB_ARB_PERF_EN. Rev 1.0
module cdb_arbiter #(
   parameter int  NUM_REQ = 4,
   parameter type T       = logic [31:0]
) (
   input  logic          clk,
   input  logic          reset,
   cdb_arbiter_if.master bus
);
   localparam int               SRC_W    = $clog2(NUM_REQ);
   localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

   logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             out_valid_q, out_valid_d;
   T                 out_data_q, out_data_d;
   logic [SRC_W-1:0] out_src_q, out_src_d;

   logic [SRC_W-1:0] winner;
   logic [SRC_W-1:0] winner_inc;
   logic             any_req;
   logic             load;
   logic             accept;

   // Explicit modulo keeps the scan index legal when NUM_REQ is not a power of two.
   function automatic logic [SRC_W-1:0] rot_idx(input logic [SRC_W-1:0] base, input int off);
      int s;
      s = 32'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return SRC_W'(s);
   endfunction

   // Scan from farthest to nearest so the requester closest to rr_ptr is left as winner.
   always_comb begin
      winner  = rr_ptr_q;
      any_req = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid[rot_idx(rr_ptr_q, k)]) begin
            winner  = rot_idx(rr_ptr_q, k);
            any_req = 1'b1;
         end
      end
   end

   assign winner_inc = (winner == LAST_IDX) ? '0 : winner + 1'b1;
   assign load       = !out_valid_q || bus.cdb_ready;
   assign accept     = load && any_req && !bus.flush && !reset;

   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_ready[i] = accept && (winner == SRC_W'(i));
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (load) begin
         out_valid_d = any_req;
         if (any_req) begin
            out_data_d = bus.req_data[winner];
            out_src_d  = winner;
            rr_ptr_d   = winner_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign bus.cdb_valid = out_valid_q;
   assign bus.cdb_data  = out_data_q;
   assign bus.cdb_src   = out_src_q;

`ifdef CDB_ARB_PERF_EN
   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
         logic [31:0] stall_cnt_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               stall_cnt_q <= '0;
            end else if (bus.req_valid[i] && !bus.req_ready[i] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
               stall_cnt_q <= stall_cnt_q + 32'd1;
            end
         end
         assign bus.perf_stall_cnt[i] = stall_cnt_q;
      end
   endgenerate
`else
   assign bus.perf_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// tb_cdb_arbiter : directed scoreboard bench for cdb_arbiter (NUM_REQ = 4). Rev 1.0
module tb_cdb_arbiter;
   localparam int NUM_REQ = 4;

`ifdef CDB_ARB_PERF_EN
   localparam logic [31:0] EXP_STALL1 = 32'd5;
   localparam logic [31:0] EXP_STALL2 = 32'd1;
`else
   localparam logic [31:0] EXP_STALL1 = 32'd0;
   localparam logic [31:0] EXP_STALL2 = 32'd0;
`endif

   typedef struct packed {
      logic [1:0]  src;
      logic [31:0] data;
   } item_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   cdb_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   cdb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   item_t      sb[$];
   int         npass = 0;
   int         nfail = 0;
   logic [7:0] tagb  = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic rdy, input logic fl);
      bus.req_valid = v;
      bus.cdb_ready = rdy;
      bus.flush     = fl;
      for (int i = 0; i < NUM_REQ; i++) bus.req_data[i] = {16'hA5A5, tagb, 8'(i)};
   endtask

   // One clock: drive at negedge, check combinational ready and the output stage
   // against the scoreboard, then record what should be accepted at the coming edge.
   task automatic cyc(input string tag, input logic [3:0] v, input logic rdy,
                      input logic fl, input logic [3:0] exp_rdy);
      item_t it;
      @(negedge clk);
      reset = 1'b0;
      drive(v, rdy, fl);
      #1;
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'(exp_rdy));
      chk({tag, ".valid"}, 32'(bus.cdb_valid), 32'(sb.size() != 0));
      if (sb.size() != 0 && bus.cdb_valid) begin
         chk({tag, ".src"},  32'(bus.cdb_src), 32'(sb[0].src));
         chk({tag, ".data"}, bus.cdb_data, sb[0].data);
         if (rdy) void'(sb.pop_front());
      end
      if (fl) sb.delete();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (exp_rdy[i]) begin
            it.src  = 2'(i);
            it.data = {16'hA5A5, tagb, 8'(i)};
            sb.push_back(it);
         end
      end
      tagb = tagb + 8'd1;
      @(posedge clk);
   endtask

   task automatic do_reset(input logic [3:0] v);
      @(negedge clk);
      reset = 1'b1;
      drive(v, 1'b0, 1'b0);
      #1;
      chk("rst.ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rst.valid", 32'(bus.cdb_valid), 32'd0);
      chk("rst.data",  bus.cdb_data, 32'd0);
      chk("rst.src",   32'(bus.cdb_src), 32'd0);
      for (int i = 0; i < NUM_REQ; i++) chk("rst.perf", bus.perf_stall_cnt[i], 32'd0);
      sb.delete();
   endtask

   initial begin
      do_reset(4'b0000);
      do_reset(4'b0000);

      // Full contention: grants rotate 0,1,2,3,0,1,2,3 with no bubble.
      for (int n = 0; n < 8; n++) cyc("rot", 4'b1111, 1'b1, 1'b0, 4'(1 << (n % 4)));
      cyc("rot_drain", 4'b0000, 1'b1, 1'b0, 4'b0000);

      // Single requester under back-pressure; payload must stay put.
      tagb = 8'h00;
      cyc("stall_acc", 4'b0100, 1'b0, 1'b0, 4'b0100);
      for (int n = 0; n < 3; n++) cyc("stall", 4'b0100, 1'b0, 1'b0, 4'b0000);
      #1;
      chk("stall_data", bus.cdb_data, 32'hA5A5_0002);
      cyc("release", 4'b0100, 1'b1, 1'b0, 4'b0100);
      cyc("drain1", 4'b0000, 1'b1, 1'b0, 4'b0000);

      // Pointer sits at 3: req 3 beats req 0, then wraps to req 0.
      cyc("rr3", 4'b1001, 1'b1, 1'b0, 4'b1000);
      cyc("rr0", 4'b1001, 1'b1, 1'b0, 4'b0001);
      cyc("drain2", 4'b0000, 1'b1, 1'b0, 4'b0000);

      // Flush while stalled, then flush while draining; pointer must be held.
      cyc("fl_load",  4'b0010, 1'b0, 1'b0, 4'b0010);
      cyc("flush",    4'b1111, 1'b0, 1'b1, 4'b0000);
      cyc("post_fl",  4'b1111, 1'b1, 1'b0, 4'b0100);
      cyc("fl_rdy",   4'b1111, 1'b1, 1'b1, 4'b0000);
      cyc("post_fl2", 4'b1111, 1'b1, 1'b0, 4'b1000);
      cyc("drain3",   4'b0000, 1'b1, 1'b0, 4'b0000);

      // Reset mid-stall with pointer at 2: first grant afterwards is lowest valid index.
      cyc("rst_load",  4'b0010, 1'b0, 1'b0, 4'b0010);
      cyc("rst_stall", 4'b0011, 1'b0, 1'b0, 4'b0000);
      do_reset(4'b0011);
      cyc("post_rst", 4'b0110, 1'b0, 1'b0, 4'b0010);

      // Req 1 stalled for five cycles behind its own held result.
      for (int n = 0; n < 5; n++) cyc("perf_stall", 4'b0010, 1'b0, 1'b0, 4'b0000);
      #1;
      chk("perf1", bus.perf_stall_cnt[1], EXP_STALL1);
      chk("perf2", bus.perf_stall_cnt[2], EXP_STALL2);
      chk("perf0", bus.perf_stall_cnt[0], 32'd0);
      cyc("drain4", 4'b0000, 1'b1, 1'b0, 4'b0000);
      cyc("idle",   4'b0000, 1'b1, 1'b0, 4'b0000);

      $display("%0d/%0d checks passed", npass, npass + nfail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) between NUM_REQ functional-unit result streams. Each requester is a valid/ready source, normally the output of a skid buffer. The block holds the winning result in one output register stage, so the CDB is driven from a flop. It also supports a pipeline flush on branch mispredict.

## Interface
- NUM_REQ, 4: number of requesters; legal values are 2 and above.
- T, logic [31:0]: payload type carried per requester.
- SRC_W, $clog2(NUM_REQ): width of the source index (derived).

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  discards the output stage; requests are not accepted this cycle.
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit is high.
- req_data  in  NUM_REQ x T  per-requester payload.
- cdb_valid  out  1  output stage holds a result.
- cdb_ready  in  1  CDB consumer accepts.
- cdb_data  out  T  granted payload.
- cdb_src  out  SRC_W  index of the requester that produced cdb_data.
- perf_stall_cnt  out  NUM_REQ x 32  per-requester stall counters (see Configuration).

## Operation
- State:
  - rr_ptr (SRC_W bits) is the highest-priority index.
  - Output register holds out_valid, out_data and out_src.
- Arbitration (combinational):
  - The winner is the first i with req_valid[i], scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - any_req means at least one req_valid bit is set.
- load = !out_valid || cdb_ready. The output stage is free, or is being drained this cycle.
- Handshake:
  - req_ready[i] = load && !flush && (i == winner) && any_req.
  - A transfer from requester i occurs when req_valid[i] && req_ready[i].
  - req_ready depends combinationally on req_valid and cdb_ready. Sources must not make valid depend on ready.
- Register update, in priority order:
  - On reset: out_valid=0, out_data='0, out_src=0, rr_ptr=0.
  - On flush: out_valid<=0. rr_ptr and out_data are held.
  - When load && any_req: out_valid<=1, out_data<=req_data[winner], out_src<=winner, and rr_ptr<=(winner+1) mod NUM_REQ.
  - When load && !any_req: out_valid<=0, rr_ptr held.
  - When !load: everything is held. Payload and source stay stable while cdb_valid && !cdb_ready.
- Outputs: cdb_valid=out_valid, cdb_data=out_data, cdb_src=out_src.
- rr_ptr wraps from NUM_REQ-1 to 0. When NUM_REQ is not a power of two, the modulo is explicit; rr_ptr never holds an illegal index.
- Fairness: with all requesters continuously valid and cdb_ready=1, grants rotate 0,1,...,NUM_REQ-1,0. Any requester waits at most NUM_REQ-1 grants.

## Timing
- Latency: 1 cycle. A transfer at edge N produces cdb_valid at N+1.
- Throughput: 1 result per cycle while cdb_ready=1.
- Back-pressure: with cdb_ready=0 and out_valid=1, all req_ready=0 the same cycle.
- Simultaneous drain and refill: with cdb_ready=1 and out_valid=1, a new winner is accepted in the same cycle. There is no bubble.
- Flush and cdb_ready=1 in the same cycle: the CDB beat is still consumed, no new request is accepted, and out_valid=0 next cycle.
- Reset asserted mid-stall: the held result is dropped and rr_ptr returns to 0. The first grant after reset goes to the lowest valid index.
- All outputs after reset: cdb_valid=0, cdb_data='0, cdb_src=0, req_ready=0 while reset is high, perf_stall_cnt=0.

## Configuration
- CDB_ARB_PERF_EN defined:
  - perf_stall_cnt[i] increments each cycle with req_valid[i] && !req_ready[i], including flush cycles.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
- CDB_ARB_PERF_EN undefined: perf_stall_cnt is constant 0 and no counter flops are built. The port list is identical in both builds.

## Test plan
- All 4 requesters valid, cdb_ready=1 for 8 cycles:
  - cdb_src sequence is 0,1,2,3,0,1,2,3, starting 1 cycle after the first accept.
  - cdb_valid stays high throughout.
- Only req 2 valid, with data 32'hA5A5_0002, cdb_ready=0 for 3 cycles:
  - cdb_data holds A5A5_0002 and req_ready stays 0 while stalled.
  - Release cdb_ready: the next item is accepted the same cycle.
- rr_ptr=3 and req 0 and req 3 both valid: req 3 wins, then rr_ptr=0 and req 0 wins next.
- Flush while cdb_valid=1 and cdb_ready=0:
  - cdb_valid=0 next cycle and no req_ready during flush.
  - rr_ptr is unchanged, checked by the next grant order.
- Reset asserted while stalled with out_valid=1: next cycle cdb_valid=0, cdb_src=0, and the first grant goes to the lowest valid index.
- Counters (CDB_ARB_PERF_EN defined): req 1 held valid through 5 stalled cycles gives perf_stall_cnt[1]=5. With the macro undefined, the same stimulus gives 0.
